// File: rtl/pp_buffer_axi_wr_master.sv
// AXI4 write master that streams 64-bit data into DDR as fixed-length INCR bursts,
// alternating between two equal regions (ping/pong) and flagging each full region.
module pp_buffer_axi_wr_master #(
  parameter int unsigned     ADDR_W    = 29,
  parameter int unsigned     DATA_W    = 64,
  parameter int unsigned     ID_W      = 4,
  parameter int unsigned     AXI_ID    = 0,
  parameter int unsigned     BURST_LEN = 16,
  parameter int unsigned     BUF_BYTES = 4096,
  parameter longint unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                buf_done,
  output logic                buf_id,
  output logic                bresp_err,
  output logic                busy
);

  localparam int unsigned BURST_BYTES = BURST_LEN * (DATA_W / 8);
  localparam int unsigned OFF_W       = $clog2(BUF_BYTES) + 1;
  localparam int unsigned BCNT_W      = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t              state;
  logic                buf_sel;
  logic [OFF_W-1:0]    offset;
  logic [BCNT_W-1:0]   beat_cnt;

  logic                go;
  logic                last_beat;
  logic [OFF_W-1:0]    off_inc;
  logic                region_full;
  logic [OFF_W-1:0]    off_next;
  logic                sel_next;
  logic                unused_bid;

  // Constant AW/W fields
  assign awid    = ID_W'(AXI_ID);
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = 3'($clog2(DATA_W / 8));
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awqos   = 4'd0;
  assign wstrb   = '1;

  // Only one transaction is ever outstanding, so the response ID carries no information
  assign unused_bid = ^bid;

  // W channel is a direct pass-through of the input stream while in W
  assign last_beat = (beat_cnt == BCNT_W'(BURST_LEN - 1));
  assign wvalid    = (state == W) & s_valid;
  assign s_ready   = (state == W) & wready;
  assign wdata     = s_data;
  assign wlast     = (state == W) & last_beat;
  assign busy      = (state != IDLE);

  assign go          = init_calib_complete & enable;
  assign off_inc     = offset + OFF_W'(BURST_BYTES);
  assign region_full = (off_inc == OFF_W'(BUF_BYTES));
  assign off_next    = region_full ? '0 : off_inc;
  assign sel_next    = buf_sel ^ region_full;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic sel, input logic [OFF_W-1:0] off);
    return ADDR_W'(BASE_ADDR) + (sel ? ADDR_W'(BUF_BYTES) : ADDR_W'(0)) + ADDR_W'(off);
  endfunction

  // Burst sequencer: AW issue, data beats, response, region bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      awaddr    <= ADDR_W'(BASE_ADDR);
      awvalid   <= 1'b0;
      bready    <= 1'b0;
      buf_done  <= 1'b0;
      buf_id    <= 1'b0;
      bresp_err <= 1'b0;
      buf_sel   <= 1'b0;
      offset    <= '0;
      beat_cnt  <= '0;
    end else begin
      buf_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            awaddr  <= burst_addr(buf_sel, offset);
            awvalid <= 1'b1;
            state   <= AW;
          end
        end
        AW: begin
          if (awready) begin
            awvalid  <= 1'b0;
            beat_cnt <= '0;
            state    <= W;
          end
        end
        W: begin
          if (s_valid && wready) begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
            if (last_beat) begin
              bready <= 1'b1;
              state  <= B;
            end
          end
        end
        B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) bresp_err <= 1'b1;
            offset  <= off_next;
            buf_sel <= sel_next;
            if (region_full) begin
              buf_done <= 1'b1;
              buf_id   <= buf_sel;
            end
            if (go) begin
              awaddr  <= burst_addr(sel_next, off_next);
              awvalid <= 1'b1;
              state   <= AW;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_buffer_axi_wr_master.sv
// Directed bench for pp_buffer_axi_wr_master: bench-side AXI slave and stream source,
// recorded AW/W/B traffic compared against hand-computed expectations.
module tb_pp_buffer_axi_wr_master;
  localparam int unsigned ADDR_W    = 29;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned BUF_BYTES = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_calib_complete = 1'b0;
  logic enable = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic awvalid;
  logic awready = 1'b0;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast, wvalid;
  logic wready = 1'b0;
  logic [ID_W-1:0] bid = '0;
  logic [1:0] bresp = 2'b00;
  logic bvalid = 1'b0;
  logic bready, buf_done, buf_id, bresp_err, busy;

  pp_buffer_axi_wr_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0),
    .BURST_LEN(BURST_LEN), .BUF_BYTES(BUF_BYTES), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .buf_done(buf_done), .buf_id(buf_id), .bresp_err(bresp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Configuration, written only by the main sequence
  bit run_en = 0;
  int aw_target = 0;
  int src_limit = 0;
  int aw_delay = 0;
  bit w_rand = 0;
  bit s_rand = 0;
  int bad_burst = 0;

  // Traffic state and records, written only by the slave/monitor loop
  int src_idx = 0;
  int aw_wait = 0;
  int b_count = 0;
  int b_to_aw = 0;
  int aw_unstable = 0;
  bit hs_pending = 0;
  bit b_pending = 0;
  bit aw_hold_v = 0;
  logic [ADDR_W-1:0] aw_hold = '0;
  logic [63:0] aw_q[$];
  logic [63:0] beat_q[$];
  int last_q[$];
  int done_q[$];
  int done_b[$];

  function automatic logic [63:0] pat(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  // AXI slave, stream source and monitor; drives at negedge, samples 1ns later
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; s_valid = 1'b0;
      hs_pending = 0; b_pending = 0; aw_hold_v = 0;
      src_idx = 0; aw_wait = 0; b_count = 0; b_to_aw = 0; aw_unstable = 0;
      aw_q.delete(); beat_q.delete(); last_q.delete(); done_q.delete(); done_b.delete();
      enable = 1'b0;
    end else begin
      if (hs_pending) src_idx++;
      if (bvalid) begin
        bvalid = 1'b0;
        b_count++;
        if (awvalid) b_to_aw++;
      end else if (b_pending && bready) begin
        bvalid = 1'b1;
        bresp = (b_count + 1 == bad_burst) ? 2'b10 : 2'b00;
        b_pending = 0;
      end
      if (buf_done) begin
        done_q.push_back(int'(buf_id));
        done_b.push_back(b_count);
      end
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (src_idx < src_limit) && (s_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_data  = pat(src_idx);
      #1;
      hs_pending = s_valid && s_ready;
      if (wvalid && wready) begin
        if (wlast) begin
          last_q.push_back(beat_q.size());
          b_pending = 1;
        end
        beat_q.push_back(wdata);
      end
      if (awvalid) begin
        if (!aw_hold_v) begin
          aw_hold = awaddr;
          aw_hold_v = 1;
        end else if (awaddr != aw_hold) begin
          aw_unstable++;
        end
        if (awready) begin
          aw_q.push_back(64'(awaddr));
          aw_hold_v = 0;
        end
      end
      enable = run_en && (aw_q.size() < aw_target);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_en = 0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!(aw_q.size() >= aw_target && !busy) && t < 4000) begin
      step(1);
      t++;
    end
    chk({tag, "_timeout"}, 64'(t >= 4000), 0);
  endtask

  function automatic logic [63:0] aw_at(input int i);
    return (i < aw_q.size()) ? aw_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic int int_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk_data(input string tag, input int n_beats);
    int errs = 0;
    for (int k = 0; k < beat_q.size(); k++)
      if (beat_q[k] !== pat(k)) errs++;
    chk({tag, "_beats"}, 64'(beat_q.size()), 64'(n_beats));
    chk({tag, "_wdata"}, 64'(errs), 0);
  endtask

  initial begin
    int cnt;
    // Reset state
    do_reset();
    chk("rst_awvalid", 64'(awvalid), 0);
    chk("rst_wvalid", 64'(wvalid), 0);
    chk("rst_wlast", 64'(wlast), 0);
    chk("rst_bready", 64'(bready), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_buf_done", 64'(buf_done), 0);
    chk("rst_bresp_err", 64'(bresp_err), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_awaddr", 64'(awaddr), 0);
    chk("const_aw", {awlen, 1'b0, awsize, 2'b0, awburst, 3'b0, awlock, awcache, awqos, 1'b0, awprot, awid},
        {8'd15, 1'b0, 3'b011, 2'b0, 2'b01, 3'b0, 1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0});
    chk("const_wstrb", 64'(wstrb), 64'hFF);

    // Scenario 3 then 1: held off by calibration, then 64 beats in four bursts
    aw_target = 4; src_limit = 64; run_en = 1;
    cnt = 0;
    repeat (100) begin
      step(1);
      if (awvalid) cnt++;
      if (s_ready) cnt++;
    end
    chk("s3_no_activity", 64'(cnt), 0);
    init_calib_complete = 1'b1;
    step(1);
    chk("s3_awvalid_next", 64'(awvalid), 1);
    wait_idle("s1");
    chk("s1_aw_count", 64'(aw_q.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s1_awaddr%0d", i), aw_at(i), 64'(i * 'h80));
    for (int i = 0; i < 4; i++) chk($sformatf("s1_wlast%0d", i), 64'(int_at(last_q, i)), 64'(i * 16 + 15));
    chk("s1_wlast_count", 64'(last_q.size()), 4);
    chk("s1_done_count", 64'(done_q.size()), 2);
    chk("s1_done_id0", 64'(int_at(done_q, 0)), 0);
    chk("s1_done_id1", 64'(int_at(done_q, 1)), 1);
    chk("s1_done_after_b2", 64'(int_at(done_b, 0)), 2);
    chk("s1_done_after_b4", 64'(int_at(done_b, 1)), 4);
    chk_data("s1", 64);
    chk("s1_bresp_err", 64'(bresp_err), 0);

    // Scenario 2: 96 beats wrap back into ping
    do_reset();
    aw_target = 6; src_limit = 96; run_en = 1;
    wait_idle("s2");
    chk("s2_awaddr4", aw_at(4), 0);
    chk("s2_awaddr5", aw_at(5), 'h80);
    chk("s2_done_count", 64'(done_q.size()), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("s2_done_id%0d", i), 64'(int_at(done_q, i)), 64'(i % 2));
    chk("s2_back_to_back", 64'(b_to_aw), 5);
    chk_data("s2", 96);
    chk("s2_bresp_err", 64'(bresp_err), 0);

    // Scenario 4: stalls on every channel
    do_reset();
    aw_delay = 5; w_rand = 1; s_rand = 1;
    aw_target = 1; src_limit = 16; run_en = 1;
    wait_idle("s4");
    chk("s4_awaddr", aw_at(0), 0);
    chk("s4_aw_stable", 64'(aw_unstable), 0);
    chk("s4_wlast_count", 64'(last_q.size()), 1);
    chk("s4_wlast_pos", 64'(int_at(last_q, 0)), 15);
    chk_data("s4", 16);
    aw_delay = 0; w_rand = 0; s_rand = 0;

    // Scenario 5: error response on the second burst
    do_reset();
    bad_burst = 2; aw_target = 3; src_limit = 48; run_en = 1;
    wait_idle("s5");
    chk("s5_bresp_err", 64'(bresp_err), 1);
    chk("s5_awaddr2", aw_at(2), 'h100);
    chk("s5_done_count", 64'(done_q.size()), 1);
    bad_burst = 0;
    step(5);
    chk("s5_err_sticky", 64'(bresp_err), 1);

    // Scenario 6: reset in the middle of the second burst
    do_reset();
    aw_target = 4; src_limit = 64; run_en = 1;
    cnt = 0;
    while (beat_q.size() < 23 && cnt < 2000) begin
      step(1);
      cnt++;
    end
    chk("s6_reach_timeout", 64'(cnt >= 2000), 0);
    chk("s6_pre_awaddr", 64'(awaddr), 'h80);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_awvalid", 64'(awvalid), 0);
    chk("s6_rst_wvalid", 64'(wvalid), 0);
    chk("s6_rst_s_ready", 64'(s_ready), 0);
    chk("s6_rst_bready", 64'(bready), 0);
    chk("s6_rst_busy", 64'(busy), 0);
    chk("s6_rst_wlast", 64'(wlast), 0);
    chk("s6_rst_awaddr", 64'(awaddr), 0);
    step(2);
    aw_target = 1; src_limit = 16;
    rst_n = 1'b1;
    wait_idle("s6");
    chk("s6_restart_awaddr", aw_at(0), 0);
    chk_data("s6", 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pp_buffer_axi_wr_master.md
# pp_buffer_axi_wr_master

Upstream AXI4 write master for the DDR4 ping-pong buffer. It accepts a 64-bit valid/ready data stream and writes it into DDR as fixed-length INCR bursts through the DDR controller's AXI4 slave port. It alternates between two equal-size regions (ping, pong) and signals when each region is full. It runs in the controller's UI clock domain and holds off until calibration completes.

## Interface
- ADDR_W, 29, AXI address width
- DATA_W, 64, AXI and stream data width (8 bytes per beat)
- ID_W, 4, AXI ID width
- AXI_ID, 0, constant value driven on awid
- BURST_LEN, 16, beats per burst; awlen = BURST_LEN-1; range 1..256
- BUF_BYTES, 4096, size of each region; must be a multiple of BURST_LEN*8
- BASE_ADDR, 0, byte address of ping; pong starts at BASE_ADDR+BUF_BYTES
- clk  in  1  DDR UI clock
- rst_n  in  1  asynchronous, active-low reset
- init_calib_complete  in  1  DDR calibration done
- enable  in  1  allows new bursts to start
- s_valid / s_ready  in / out  1 / 1  input stream handshake
- s_data  in  DATA_W  input stream data
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid  out  per AXI4  AW channel
- awready  in  1  AW channel ready
- wdata, wstrb, wlast, wvalid  out  DATA_W, DATA_W/8, 1, 1  W channel
- wready  in  1  W channel ready
- bid, bresp, bvalid  in  ID_W, 2, 1  B channel
- bready  out  1  B channel ready
- buf_done  out  1  one-cycle pulse when a region is fully written
- buf_id  out  1  region just completed: 0 = ping, 1 = pong; valid with buf_done
- bresp_err  out  1  sticky; set on any bresp other than 2'b00; cleared only by reset
- busy  out  1  high in any state other than IDLE

## Operation
- Constant AW fields:
  - awsize = 3'b011, awburst = 2'b01 (INCR), awlen = BURST_LEN-1
  - awlock, awcache, awprot, awqos = 0
  - awid = AXI_ID; wstrb = all ones
- Internal state:
  - buf_sel (1 bit)
  - offset: byte offset within the current region, width clog2(BUF_BYTES)+1
  - beat_cnt: width clog2(BURST_LEN)+1
- FSM states: IDLE, AW, W, B.
- IDLE → AW when init_calib_complete & enable. On entry to AW, register awaddr = BASE_ADDR + buf_sel*BUF_BYTES + offset and set awvalid.
- AW: hold awvalid and awaddr stable until awready. On the handshake, drop awvalid, clear beat_cnt, go to W.
- W: combinational pass-through.
  - wvalid = s_valid, s_ready = wready, wdata = s_data.
  - wlast = (beat_cnt == BURST_LEN-1).
  - Each wvalid & wready increments beat_cnt. The beat with wlast moves the FSM to B.
  - s_ready = 0 in every state except W.
- B: bready = 1. On bvalid:
  - If bresp != 0, set bresp_err.
  - offset += BURST_LEN*8.
  - If the new offset == BUF_BYTES: pulse buf_done with buf_id = buf_sel, toggle buf_sel, clear offset.
  - Next state: AW if init_calib_complete & enable, otherwise IDLE.
- The B check ignores bid; only one transaction is ever outstanding.
- enable low mid-burst: the current burst completes through B, then the FSM returns to IDLE. The address position is retained and resumes on the next enable.
- init_calib_complete is sampled only in IDLE and on B exit.
- Address arithmetic is truncated to ADDR_W. Bursts never cross the region end, given the BUF_BYTES constraint.

## Timing
- Reset values:
  - awvalid, wvalid, wlast, bready, s_ready, buf_done, bresp_err, busy = 0
  - awaddr = BASE_ADDR; buf_sel = 0; offset = 0
  - FSM = IDLE
- Reset mid-burst aborts immediately. After release, writing restarts at BASE_ADDR in ping.
- awvalid rises the cycle after IDLE sees calib & enable high.
- W → B transition is in the cycle after the wlast handshake. bready is high from that cycle until bvalid.
- buf_done is high for exactly the cycle after the bvalid handshake that completes the region.
- Back-to-back: bvalid in cycle N gives awvalid for the next burst in cycle N+1.
- Stall behaviour: s_valid low inserts W-channel bubbles (wvalid low). wready low stalls the stream (s_ready low). No data is lost or duplicated.

## Test plan
- Setup for all scenarios: BUF_BYTES=256, BURST_LEN=16, BASE_ADDR=0.
- Scenario 1: stream counting data 0..63 with always-ready slave → awaddr sequence 0x000, 0x080, 0x100, 0x180; wlast on beats 15, 31, 47, 63; buf_done with buf_id=0 after the 2nd B and buf_id=1 after the 4th B; wdata equals the input order.
- Scenario 2: write 96 beats → 5th burst awaddr wraps to 0x000, buf_id sequence 0, 1, 0.
- Scenario 3: init_calib_complete low with enable high for 100 cycles → awvalid and s_ready stay 0; calib rises → awvalid the next cycle.
- Scenario 4: random wready/s_valid gaps plus awready delayed 5 cycles → awaddr stable while waiting; 16 beats delivered intact; exactly one wlast.
- Scenario 5: bresp=2'b10 on the 2nd burst → bresp_err set and held; the address still advances to 0x100.
- Scenario 6: assert rst_n low at beat 7 of the 2nd burst → all outputs at reset values immediately; after release the next awaddr = 0x000.
